// File: rtl/run_pattern_gen.sv
// run_pattern_gen: buffers run commands {bit, len} in a small FIFO and
// serializes them onto the detector input w. z_exp predicts, cycle by cycle,
// when a four-in-a-row detector watching w should assert.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no run in progress, w holds its last value, w_valid low
// DRIVE | w carries a commanded bit, remaining counts down to the run end

module run_pattern_gen #(
  parameter int LEN_W = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_bit,
  input  logic [LEN_W-1:0]       cmd_len,
  output logic                   w,
  output logic                   w_valid,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   z_exp
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {S_IDLE, S_DRIVE} state_t;

  state_t             state;
  logic [LEN_W:0]     mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [LEN_W-1:0]   remaining;
  logic [LEN_W:0]     head;
  logic               push;
  logic               pop;
  logic [2:0]         streak;
  logic [2:0]         streak_next;
  logic               w_prev;

  // Ready looks only at the current count, so a full FIFO never accepts even
  // when the head is leaving on the same edge.
  assign cmd_ready  = (count < FULL_CNT);
  assign push       = cmd_valid && cmd_ready;
  assign head       = mem[rd_ptr];
  // A new command is taken when idle, or on the last cycle of the current run
  // so consecutive runs follow each other without a gap.
  assign pop        = (count != '0) &&
                      ((state == S_IDLE) || (remaining == '0));
  assign busy       = (state == S_DRIVE) || (count != '0);
  assign fifo_count = count;

  // Command FIFO: storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {cmd_bit, cmd_len};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Serializer FSM with registered w / w_valid and the run-length down-counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      w         <= 1'b0;
      w_valid   <= 1'b0;
      remaining <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            w         <= head[LEN_W];
            remaining <= head[LEN_W-1:0];
            w_valid   <= 1'b1;
            state     <= S_DRIVE;
          end else begin
            w_valid <= 1'b0;
          end
        end
        S_DRIVE: begin
          if (remaining == '0) begin
            if (pop) begin
              w         <= head[LEN_W];
              remaining <= head[LEN_W-1:0];
              w_valid   <= 1'b1;
            end else begin
              w_valid <= 1'b0;
              state   <= S_IDLE;
            end
          end else begin
            remaining <= remaining - 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          w_valid <= 1'b0;
        end
      endcase
    end
  end

  // Streak length of identical w samples, saturating at four; idle hold
  // cycles count because the detector samples w every clock.
  always_comb begin
    streak_next = 3'd1;
    if (streak == 3'd0) begin
      streak_next = 3'd1;
    end else if (w == w_prev) begin
      streak_next = (streak == 3'd4) ? 3'd4 : streak + 3'd1;
    end
  end

  // Expected detector output, registered together with the streak.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak <= 3'd0;
      w_prev <= 1'b0;
      z_exp  <= 1'b0;
    end else begin
      streak <= streak_next;
      w_prev <= w;
      z_exp  <= (streak_next == 3'd4);
    end
  end

endmodule

// File: doc/run_pattern_gen.md
# run_pattern_gen

Run-length pattern transmitter for the consecutive-value detector: it accepts run commands (bit value, run length) through a valid/ready port, buffers them in a small FIFO, and serializes them onto the detector's `w` input one bit per clock. It also produces `z_exp`, a cycle-accurate prediction of when the detector should assert `z` (four or more identical consecutive `w` samples, overlapping runs included). The bench compares `z_exp` against `z`. The block sits between the test sequencer and the detector.

## Interface
- `LEN_W`, 4: width of the run-length field; a run is `cmd_len+1` cycles long, so 1..2^LEN_W.
- `DEPTH`, 4: command FIFO depth; must be a power of 2 and at least 2.
- `clk`  in  1  clock; all logic runs on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low. It clears all state, including FIFO contents.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO can accept; combinational `count < DEPTH`.
- `cmd_bit`  in  1  value to drive for the run.
- `cmd_len`  in  LEN_W  run length minus one.
- `w`  out  1  serialized detector input; registered.
- `w_valid`  out  1  high while `w` carries a commanded run bit; registered.
- `busy`  out  1  high while FIFO is non-empty or a run is in progress.
- `fifo_count`  out  clog2(DEPTH)+1  number of buffered commands.
- `z_exp`  out  1  predicted detector output; registered.

## Operation
- Push: when `cmd_valid && cmd_ready`, write {`cmd_bit`, `cmd_len`} at the tail. `cmd_ready` depends only on the current count. It ignores a same-cycle pop, so a full FIFO never accepts a command.
- Serializer FSM, two states:
  - IDLE: `w_valid`=0 and `w` holds its last value. If the FIFO is non-empty, pop the head, load `w`=bit, `remaining`=len, set `w_valid`=1, and go to DRIVE.
  - DRIVE: `w` is held for `remaining+1` cycles total. When `remaining`=0:
    - If the FIFO is non-empty, pop the next command and load it on the same edge. There is no gap cycle and the state stays DRIVE.
    - If the FIFO is empty, go to IDLE and set `w_valid`=0.
  - Otherwise decrement `remaining`.
- Simultaneous push and pop: the count is unchanged and the pointers wrap modulo DEPTH. A push into an empty FIFO while in IDLE is not bypassed; it goes through the FIFO.
- `busy` = (state==DRIVE) || (count != 0).
- Expected-output model, evaluated every clock regardless of `w_valid`:
  - The detector samples `w` continuously, so idle hold cycles count toward a streak.
  - `streak` is a 3-bit register, saturating at 4. Each edge:
    - if `streak`==0, `streak`←1;
    - else if `w`==`w_prev`, `streak`←min(`streak`+1, 4);
    - else `streak`←1.
  - `w_prev`←`w` on every edge.
  - `z_exp` = (`streak`==4), registered with the streak.
- Reset mid-run: the run is aborted, the FIFO is emptied, and the pointers and `remaining` are cleared. The FSM restarts in IDLE on the first edge after `rst` deasserts.

## Timing
- Reset values: `w`=0, `w_valid`=0, `busy`=0, `fifo_count`=0, `z_exp`=0, `streak`=0, `w_prev`=0, FSM=IDLE. `cmd_ready`=1 whenever count < DEPTH, including during reset.
- Latency:
  - A command accepted at edge k into an empty FIFO in IDLE drives `w` from edge k+1; `w_valid` is high in cycle k+1.
  - `busy` rises in the cycle after the accepting edge.
  - Back-to-back commands produce a continuous `w_valid`.
- `z_exp` rises in the cycle after the 4th consecutive equal `w` cycle. It falls in the cycle after `w` changes value.
- Maximum throughput is one command per cycle when every `cmd_len`=0.

## Test plan
- Single run: push {bit=1, len=3} into an empty idle block. Required: `w`=1 and `w_valid`=1 for exactly 4 cycles, then `w_valid`=0 with `w` held at 1. `z_exp`=1 starting the cycle after the 4th `w_valid` cycle, and it stays 1 while `w` holds.
- Alternation: push 6 commands {1,0},{0,0},{1,0},{0,0},{1,0},{0,0} back-to-back. Required: `w` toggles every cycle with no gaps, `w_valid` is continuous for 6 cycles, and `z_exp` never asserts during the toggling.
- Overlap: push {1,5} then {0,4}. Required:
  - `z_exp` rises after the 4th 1 and stays high through the 6th.
  - It drops the cycle after `w`→0.
  - It rises again after the 4th 0.
- Full FIFO: push 6 commands {1,7} without waiting. Required:
  - After the first pop, `cmd_ready` drops once `fifo_count`=4, and the 6th command stalls.
  - `cmd_ready` re-asserts on the cycle after the first 8-cycle run ends.
- Reset mid-run: with 3 commands queued and a {1,15} run at remaining=9, assert `rst` low for 2 cycles. Required:
  - `w`=0, `w_valid`=0, `busy`=0, `fifo_count`=0, and `z_exp`=0 immediately, without waiting for a clock.
  - No queued bits appear after release.
- Wrap-around: push and pop 10 commands with lengths 0..9 while the FIFO is full at intervals. Required: the `w` sequence matches command order exactly, with per-run cycle counts 1..10.
